// File: rtl/ps2_zx_keyboard.sv
// PS/2 scan-set-2 receiver feeding an 8x5 ZX key matrix that drives the ULA KB lines.
// Optional macro PS2_COMPOSITE_EN adds chorded keys (Backspace and the arrows).
module ps2_zx_keyboard #(
    parameter int unsigned TIMEOUT_CYCLES = 14000,
    parameter int unsigned TO_W           = 14
) (
    input  logic       OSC,
    input  logic       n_RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic [7:0] A,
    output logic [4:0] KB,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       FRAME_ERR
);

`ifdef PS2_COMPOSITE_EN
    localparam int unsigned NKEYS = 47;
`else
    localparam int unsigned NKEYS = 42;
`endif
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t            state;
    logic [2:0]        clk_sync;
    logic [1:0]        dat_sync;
    logic              fall, ps2_data;
    logic [7:0]        shreg;
    logic [2:0]        bitcnt;
    logic              par_bit;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout, frame_ok, frame_bad;
    logic [NKEYS-1:0]  keys;
    logic              brk, ext;
    logic [6:0]        hit;
    logic [39:0]       m;

    always_ff @(posedge OSC or negedge n_RESET) begin
        if (!n_RESET) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
        end
    end

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign ps2_data = dat_sync[1];

    assign timeout   = (state != ST_IDLE) && !fall && (to_cnt >= TO_LAST);
    assign frame_ok  = fall && (state == ST_STOP) && (^{shreg, par_bit}) && ps2_data;
    assign frame_bad = (fall && (state == ST_STOP) && !((^{shreg, par_bit}) && ps2_data)) || timeout;

    always_ff @(posedge OSC or negedge n_RESET) begin
        if (!n_RESET) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            SCAN_CODE  <= '0;
            SCAN_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            SCAN_VALID <= frame_ok;
            FRAME_ERR  <= frame_bad;
            if (frame_ok)
                SCAN_CODE <= shreg;
            if (fall || state == ST_IDLE)
                to_cnt <= '0;
            else if (to_cnt != '1)
                to_cnt <= to_cnt + 1'b1;
            if (timeout) begin
                state <= ST_IDLE;
            end else if (fall) begin
                case (state)
                    ST_IDLE: if (!ps2_data) begin
                        state  <= ST_DATA;
                        bitcnt <= '0;
                    end
                    ST_DATA: begin
                        shreg  <= {ps2_data, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= ps2_data;
                        state   <= ST_STOP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Returns {hit, key index}; 0..39 = row*5+bit, 40 R-Shift, 41 R-Ctrl, 42..46 composites.
    function automatic logic [6:0] lookup(input logic e, input logic [7:0] code);
        logic [6:0] r;
        r = '0;
        case ({e, code})
            9'h012: r = {1'b1, 6'd0};  9'h01A: r = {1'b1, 6'd1};  9'h022: r = {1'b1, 6'd2};
            9'h021: r = {1'b1, 6'd3};  9'h02A: r = {1'b1, 6'd4};
            9'h01C: r = {1'b1, 6'd5};  9'h01B: r = {1'b1, 6'd6};  9'h023: r = {1'b1, 6'd7};
            9'h02B: r = {1'b1, 6'd8};  9'h034: r = {1'b1, 6'd9};
            9'h015: r = {1'b1, 6'd10}; 9'h01D: r = {1'b1, 6'd11}; 9'h024: r = {1'b1, 6'd12};
            9'h02D: r = {1'b1, 6'd13}; 9'h02C: r = {1'b1, 6'd14};
            9'h016: r = {1'b1, 6'd15}; 9'h01E: r = {1'b1, 6'd16}; 9'h026: r = {1'b1, 6'd17};
            9'h025: r = {1'b1, 6'd18}; 9'h02E: r = {1'b1, 6'd19};
            9'h045: r = {1'b1, 6'd20}; 9'h046: r = {1'b1, 6'd21}; 9'h03E: r = {1'b1, 6'd22};
            9'h03D: r = {1'b1, 6'd23}; 9'h036: r = {1'b1, 6'd24};
            9'h04D: r = {1'b1, 6'd25}; 9'h044: r = {1'b1, 6'd26}; 9'h043: r = {1'b1, 6'd27};
            9'h03C: r = {1'b1, 6'd28}; 9'h035: r = {1'b1, 6'd29};
            9'h05A: r = {1'b1, 6'd30}; 9'h04B: r = {1'b1, 6'd31}; 9'h042: r = {1'b1, 6'd32};
            9'h03B: r = {1'b1, 6'd33}; 9'h033: r = {1'b1, 6'd34};
            9'h029: r = {1'b1, 6'd35}; 9'h014: r = {1'b1, 6'd36}; 9'h03A: r = {1'b1, 6'd37};
            9'h031: r = {1'b1, 6'd38}; 9'h032: r = {1'b1, 6'd39};
            9'h059: r = {1'b1, 6'd40}; 9'h114: r = {1'b1, 6'd41};
`ifdef PS2_COMPOSITE_EN
            9'h066: r = {1'b1, 6'd42}; 9'h16B: r = {1'b1, 6'd43}; 9'h172: r = {1'b1, 6'd44};
            9'h175: r = {1'b1, 6'd45}; 9'h174: r = {1'b1, 6'd46};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign hit = lookup(ext, shreg);

    always_ff @(posedge OSC or negedge n_RESET) begin
        if (!n_RESET) begin
            keys <= '0;
            brk  <= 1'b0;
            ext  <= 1'b0;
        end else if (frame_bad) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (frame_ok) begin
            if (shreg == 8'hF0) begin
                brk <= 1'b1;
            end else if (shreg == 8'hE0) begin
                ext <= 1'b1;
            end else begin
                if (hit[6])
                    keys[hit[5:0]] <= ~brk;
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    // Second host keys and chords are kept apart so each release only drops its own bit.
    always_comb begin
        m     = keys[39:0];
        m[0]  = keys[0] | keys[40];
        m[36] = keys[36] | keys[41];
`ifdef PS2_COMPOSITE_EN
        m[0]  = m[0] | (|keys[46:42]);
        m[20] = m[20] | keys[42];
        m[19] = m[19] | keys[43];
        m[24] = m[24] | keys[44];
        m[23] = m[23] | keys[45];
        m[22] = m[22] | keys[46];
`endif
    end

    always_comb begin
        KB = '1;
        for (int unsigned j = 0; j < 5; j++)
            for (int unsigned i = 0; i < 8; i++)
                if (!A[i] && m[i*5 + j])
                    KB[j] = 1'b0;
    end

endmodule
